ball_physics: RTL
=================

# ball_physics

Ball (square) motion engine for the Pong datapath. It owns the square's position and direction, bounces it off the top/bottom walls and both paddles, and detects misses at the left/right edges. Its outputs `sq_xpos`, `sq_ypos`, `sq_xveldir` and `sq_missed` drive the AI paddle controller and the renderer. `point_p1` and `point_p2` drive the score counters. Player 1's paddle is on the left and player 2 (AI) is on the right.

## Interface
- `CLK_HZ`, 25_175_000, clock frequency in Hz
- `H_VIDEO`, 640, visible width in pixels
- `V_VIDEO`, 480, visible height in pixels
- `SQ_WIDTH`, 16, square side length
- `PDL_HEIGHT`, 96, paddle height
- `PDL_WIDTH`, 8, paddle width
- `P1_X`, 16, x of the left paddle's left edge
- `P2_X`, 616, x of the right paddle's left edge
- `SPEED`, 300, ball speed in px/s per axis
- `SERVE_DELAY`, 1000, ms the ball is held centred before launch
- `MISS_DELAY`, 1000, ms the ball is frozen after a miss

Ports:
- `clk_0`  in  1  system clock
- `rst`  in  1  synchronous, active-low reset
- `reset_game`  in  1  synchronous game restart, active-high
- `p1_ypos`  in  10  top of the left paddle
- `p2_ypos`  in  10  top of the right paddle
- `sq_xpos`  out  10  left edge of the square
- `sq_ypos`  out  10  top edge of the square
- `sq_xveldir`  out  1  1 = moving right (toward P2)
- `sq_yveldir`  out  1  1 = moving down
- `sq_missed`  out  1  high while in MISSED
- `point_p1`  out  1  one-cycle pulse: P1 scored
- `point_p2`  out  1  one-cycle pulse: P2 scored

## Operation
- Derived constants:
  - `PSC_LIMIT = CLK_HZ/SPEED`
  - `SERVE_PSC = SERVE_DELAY*(CLK_HZ/1000)`
  - `MISS_PSC = MISS_DELAY*(CLK_HZ/1000)`
  - `XC = (H_VIDEO-SQ_WIDTH)/2`
  - `YC = (V_VIDEO-SQ_WIDTH)/2`
- Reset (`rst`=0, or `reset_game`=1 with `rst` taking priority):
  - state SERVE, counters cleared
  - `sq_xpos`=XC (312), `sq_ypos`=YC (232)
  - `sq_xveldir`=1, `sq_yveldir`=1
  - `sq_missed`=0, `point_p1`=`point_p2`=0
- FSM states:
  - **SERVE**: ball held at (XC,YC). The delay counter runs to SERVE_PSC, then the FSM enters PLAY and clears the velocity counter.
  - **PLAY**: the velocity counter counts 0..PSC_LIMIT. At terminal count a step tick fires and the counter wraps to 0. All updates below happen on the step tick only, using registered position and the current paddle inputs.
  - **MISSED**: `sq_missed`=1 and the ball is frozen. The delay counter runs to MISS_PSC. The FSM then recentres to (XC,YC), sets `sq_xveldir` toward the player who conceded, toggles `sq_yveldir`, and enters SERVE.
- Overlap test for paddle `py`: `sq_ypos+SQ_WIDTH > py` and `sq_ypos < py+PDL_HEIGHT`. Evaluate at 11 bits; there is no wrap.
- Vertical step:
  - `sq_yveldir`=1 and `sq_ypos` ≥ V_VIDEO-SQ_WIDTH → `sq_yveldir`←0, `sq_ypos`←`sq_ypos`-1
  - `sq_yveldir`=0 and `sq_ypos`=0 → `sq_yveldir`←1, `sq_ypos`←1
  - otherwise `sq_ypos`±1
- Horizontal step, moving right:
  - `sq_xpos+SQ_WIDTH`=P2_X and overlap(`p2_ypos`) → `sq_xveldir`←0, `sq_xpos`-1
  - else `sq_xpos`=H_VIDEO-SQ_WIDTH → `point_p1` pulse, enter MISSED
  - else `sq_xpos`+1
- Horizontal step, moving left:
  - `sq_xpos`=P1_X+PDL_WIDTH and overlap(`p1_ypos`) → `sq_xveldir`←1, `sq_xpos`+1
  - else `sq_xpos`=0 → `point_p2` pulse, enter MISSED
  - else `sq_xpos`-1
- Vertical and horizontal rules apply independently on the same tick (corner hit = double bounce).
- On the miss tick, y does not move.

## Timing
- All outputs are registered and change only on the `clk_0` rising edge.
- Reset takes effect on the first edge with `rst`=0; outputs show reset values the following cycle.
- The first move is SERVE_PSC+PSC_LIMIT+1 cycles after reset release (±1 for counter compare). Each subsequent move follows PSC_LIMIT+1 cycles later.
- `point_pX` goes high for exactly one cycle, coincident with the edge that enters MISSED.
- `sq_missed` rises on that same edge and stays high for MISS_PSC+1 cycles.
- `reset_game` during MISSED or PLAY aborts the current state and produces no point pulse.
- Paddle inputs are sampled only on step ticks; changes between ticks are ignored.

## Structure
- Shared package `pong_pkg`:
  - screen dimensions, SQ_WIDTH, PDL_HEIGHT, PDL_WIDTH, CLK_HZ
  - FSM state encoding
  - a ms→cycles constant function
- Sub-module `rate_tick` (parameter LIMIT; ports `clk_0`, `rst`, `clr`, `en`, `tick`): a counter that pulses `tick` when it reaches LIMIT. Instantiate it for the velocity counter; the delay counter can reuse it.

## Test plan
Simulation uses overrides CLK_HZ=1000, SPEED=500 (PSC_LIMIT=2), and SERVE_DELAY=MISS_DELAY=4 (4 cycles each).
- **Reset:** `rst`=0 for one cycle → (312,232), `sq_xveldir`=1, `sq_missed`=0; after the serve delay the ball steps to (313,233).
- **Bottom bounce:** ball reaches `sq_ypos`=464 moving down → next tick `sq_yveldir`=0, `sq_ypos`=463.
- **P2 hit:** `p2_ypos`=200 with the ball arriving at `sq_xpos`=600, `sq_ypos` in 185..295 → `sq_xveldir`=0, `sq_xpos`=599.
- **Overlap boundary:** `sq_ypos`=`p2_ypos`-16 → miss; `sq_ypos`=`p2_ypos`-15 → hit.
- **P2 miss:** `p2_ypos`=0, ball `sq_ypos` >120 → ball reaches 624. Next tick: `point_p1` high one cycle, `sq_missed` high 5 cycles, then recentre at (312,232) with `sq_xveldir`=1 and `sq_yveldir` toggled.
- **Mid-play restart:** pulse `reset_game` mid-PLAY → (312,232), SERVE, no point pulse, serve timing restarts.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants, ball FSM state encoding and a ms-to-cycles helper.
package pong_pkg;

  localparam int unsigned DefClkHz     = 25_175_000;
  localparam int unsigned DefHVideo    = 640;
  localparam int unsigned DefVVideo    = 480;
  localparam int unsigned DefSqWidth   = 16;
  localparam int unsigned DefPdlHeight = 96;
  localparam int unsigned DefPdlWidth  = 8;

  typedef enum logic [1:0] {
    StServe,
    StPlay,
    StMissed
  } ball_state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned ms, input int unsigned clk_hz);
    return ms * (clk_hz / 1000);
  endfunction

endpackage

// File: rtl/rate_tick.sv
// Free-running prescaler: counts 0..LIMIT while enabled and pulses tick at terminal count.
module rate_tick #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk_0,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned Width = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [Width-1:0] Lim = Width'(LIMIT);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Lim);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ball_physics.sv
// Pong ball motion: serve hold, wall and paddle bounces, miss detection and scoring pulses.
module ball_physics
  import pong_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DefClkHz,
  parameter int unsigned H_VIDEO     = DefHVideo,
  parameter int unsigned V_VIDEO     = DefVVideo,
  parameter int unsigned SQ_WIDTH    = DefSqWidth,
  parameter int unsigned PDL_HEIGHT  = DefPdlHeight,
  parameter int unsigned PDL_WIDTH   = DefPdlWidth,
  parameter int unsigned P1_X        = 16,
  parameter int unsigned P2_X        = 616,
  parameter int unsigned SPEED       = 300,
  parameter int unsigned SERVE_DELAY = 1000,
  parameter int unsigned MISS_DELAY  = 1000
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       reset_game,
  input  logic [9:0] p1_ypos,
  input  logic [9:0] p2_ypos,
  output logic [9:0] sq_xpos,
  output logic [9:0] sq_ypos,
  output logic       sq_xveldir,
  output logic       sq_yveldir,
  output logic       sq_missed,
  output logic       point_p1,
  output logic       point_p2
);

  localparam int unsigned PscLimit = CLK_HZ / SPEED;
  localparam int unsigned ServePsc = ms_to_cycles(SERVE_DELAY, CLK_HZ);
  localparam int unsigned MissPsc  = ms_to_cycles(MISS_DELAY, CLK_HZ);

  localparam logic [9:0]  Xc     = 10'((H_VIDEO - SQ_WIDTH) / 2);
  localparam logic [9:0]  Yc     = 10'((V_VIDEO - SQ_WIDTH) / 2);
  localparam logic [9:0]  XMax   = 10'(H_VIDEO - SQ_WIDTH);
  localparam logic [9:0]  YMax   = 10'(V_VIDEO - SQ_WIDTH);
  localparam logic [10:0] P1Face = 11'(P1_X + PDL_WIDTH);
  localparam logic [10:0] P2Face = 11'(P2_X);
  localparam logic [10:0] SqW    = 11'(SQ_WIDTH);
  localparam logic [10:0] PdlH   = 11'(PDL_HEIGHT);

  ball_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        xdir_q, xdir_d, ydir_q, ydir_d;
  logic        missed_q, missed_d, pt1_q, pt1_d, pt2_q, pt2_d;
  logic        side_miss;
  logic        vel_tick, serve_done, miss_done;

  // Widened to 11 bits so the paddle window never wraps near the screen bottom.
  function automatic logic overlap(input logic [9:0] sy, input logic [9:0] py);
    return (({1'b0, sy} + SqW) > {1'b0, py}) && ({1'b0, sy} < ({1'b0, py} + PdlH));
  endfunction

  rate_tick #(.LIMIT(PscLimit)) u_vel_tick (
    .clk_0(clk_0),
    .rst  (rst),
    .clr  (reset_game || (state_q != StPlay)),
    .en   (state_q == StPlay),
    .tick (vel_tick)
  );

  rate_tick #(.LIMIT(ServePsc)) u_serve_tick (
    .clk_0(clk_0),
    .rst  (rst),
    .clr  (reset_game || (state_q != StServe)),
    .en   (state_q == StServe),
    .tick (serve_done)
  );

  rate_tick #(.LIMIT(MissPsc)) u_miss_tick (
    .clk_0(clk_0),
    .rst  (rst),
    .clr  (reset_game || (state_q != StMissed)),
    .en   (state_q == StMissed),
    .tick (miss_done)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    xdir_d    = xdir_q;
    ydir_d    = ydir_q;
    pt1_d     = 1'b0;
    pt2_d     = 1'b0;
    side_miss = 1'b0;
    unique case (state_q)
      StServe: begin
        if (serve_done) state_d = StPlay;
      end
      StPlay: begin
        if (vel_tick) begin
          if (xdir_q) begin
            if ((({1'b0, x_q} + SqW) == P2Face) && overlap(y_q, p2_ypos)) begin
              xdir_d = 1'b0;
              x_d    = x_q - 10'd1;
            end else if (x_q == XMax) begin
              pt1_d     = 1'b1;
              side_miss = 1'b1;
            end else begin
              x_d = x_q + 10'd1;
            end
          end else begin
            if (({1'b0, x_q} == P1Face) && overlap(y_q, p1_ypos)) begin
              xdir_d = 1'b1;
              x_d    = x_q + 10'd1;
            end else if (x_q == 10'd0) begin
              pt2_d     = 1'b1;
              side_miss = 1'b1;
            end else begin
              x_d = x_q - 10'd1;
            end
          end
          // y is frozen on the tick that detects a miss.
          if (side_miss) begin
            state_d = StMissed;
          end else if (ydir_q && (y_q >= YMax)) begin
            ydir_d = 1'b0;
            y_d    = y_q - 10'd1;
          end else if (!ydir_q && (y_q == 10'd0)) begin
            ydir_d = 1'b1;
            y_d    = 10'd1;
          end else begin
            y_d = ydir_q ? y_q + 10'd1 : y_q - 10'd1;
          end
        end
      end
      StMissed: begin
        // xdir still points at the side that conceded, so it is kept as is.
        if (miss_done) begin
          state_d = StServe;
          x_d     = Xc;
          y_d     = Yc;
          ydir_d  = !ydir_q;
        end
      end
      default: state_d = StServe;
    endcase
    missed_d = (state_d == StMissed);
  end

  always_ff @(posedge clk_0) begin
    if (!rst || reset_game) begin
      state_q  <= StServe;
      x_q      <= Xc;
      y_q      <= Yc;
      xdir_q   <= 1'b1;
      ydir_q   <= 1'b1;
      missed_q <= 1'b0;
      pt1_q    <= 1'b0;
      pt2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xdir_q   <= xdir_d;
      ydir_q   <= ydir_d;
      missed_q <= missed_d;
      pt1_q    <= pt1_d;
      pt2_q    <= pt2_d;
    end
  end

  assign sq_xpos    = x_q;
  assign sq_ypos    = y_q;
  assign sq_xveldir = xdir_q;
  assign sq_yveldir = ydir_q;
  assign sq_missed  = missed_q;
  assign point_p1   = pt1_q;
  assign point_p2   = pt2_q;

endmodule
